// File: rtl/pipelined_controller_pkg.sv
// Shared decode constants and per-stage control word types for the pipelined MIPS controller.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam int unsigned ALU_CODE_W = 3;

    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_CODE_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_CODE_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic                  regwrite;
        logic                  memtoreg;
        logic                  memwrite;
        logic                  alusrc;
        logic                  regdst;
        logic                  zeroext;
        logic [ALU_CODE_W-1:0] alucontrol;
        logic                  valid;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Later stages only carry the fields they still consume.
    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
        logic valid;
    } mem_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic valid;
    } wb_ctrl_t;

endpackage

// File: rtl/pipelined_controller_if.sv
// Decode inputs, hazard controls and per-stage control outputs of the pipelined controller.
interface pipe_ctrl_if #(
    parameter int unsigned ALUCTRL_W    = 3,
    parameter int unsigned RETIRE_CNT_W = 16
);
    logic [5:0]              opcodeD;
    logic [5:0]              functD;
    logic                    stallE;
    logic                    flushE;
    logic                    branchD;
    logic                    jumpD;
    logic                    illegalD;
    logic                    regwriteE;
    logic                    regwriteM;
    logic                    regwriteW;
    logic                    memtoregE;
    logic                    memtoregM;
    logic                    memtoregW;
    logic                    memwriteE;
    logic                    memwriteM;
    logic                    alusrcE;
    logic                    regdstE;
    logic                    zeroextE;
    logic [ALUCTRL_W-1:0]    alucontrolE;
    logic                    validW;
    logic [RETIRE_CNT_W-1:0] retire_cnt;

    modport master (
        output opcodeD, functD, stallE, flushE,
        input  branchD, jumpD, illegalD, regwriteE, regwriteM, regwriteW,
               memtoregE, memtoregM, memtoregW, memwriteE, memwriteM, alusrcE,
               regdstE, zeroextE, alucontrolE, validW, retire_cnt
    );

    modport slave (
        input  opcodeD, functD, stallE, flushE,
        output branchD, jumpD, illegalD, regwriteE, regwriteM, regwriteW,
               memtoregE, memtoregM, memtoregW, memwriteE, memwriteM, alusrcE,
               regdstE, zeroextE, alucontrolE, validW, retire_cnt
    );
endinterface

// File: rtl/pipelined_controller_decode.sv
// Combinational opcode/funct decoder producing the control word, branch, jump and illegal flags.
// PIPECTRL_IMM_LOGIC_EN adds andi/ori/slti; otherwise they decode as illegal.
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output ctrl_t      ctrl_o,
    output logic       branch_o,
    output logic       jump_o,
    output logic       illegal_o
);

    ctrl_t ctrl;
    logic  illegal;

    always_comb begin
        ctrl     = CTRL_BUBBLE;
        branch_o = 1'b0;
        jump_o   = 1'b0;
        illegal  = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
                case (funct_i)
                    FN_ADD:  ctrl.alucontrol = ALU_ADD;
                    FN_SUB:  ctrl.alucontrol = ALU_SUB;
                    FN_AND:  ctrl.alucontrol = ALU_AND;
                    FN_OR:   ctrl.alucontrol = ALU_OR;
                    FN_SLT:  ctrl.alucontrol = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                ctrl.regwrite   = 1'b1;
                ctrl.alusrc     = 1'b1;
                ctrl.memtoreg   = 1'b1;
                ctrl.alucontrol = ALU_ADD;
            end
            OP_SW: begin
                ctrl.alusrc     = 1'b1;
                ctrl.memwrite   = 1'b1;
                ctrl.alucontrol = ALU_ADD;
            end
            OP_BEQ: begin
                branch_o        = 1'b1;
                ctrl.alucontrol = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl.regwrite   = 1'b1;
                ctrl.alusrc     = 1'b1;
                ctrl.alucontrol = ALU_ADD;
            end
            OP_J: jump_o = 1'b1;
`ifdef PIPECTRL_IMM_LOGIC_EN
            OP_ANDI: begin
                ctrl.regwrite   = 1'b1;
                ctrl.alusrc     = 1'b1;
                ctrl.zeroext    = 1'b1;
                ctrl.alucontrol = ALU_AND;
            end
            OP_ORI: begin
                ctrl.regwrite   = 1'b1;
                ctrl.alusrc     = 1'b1;
                ctrl.zeroext    = 1'b1;
                ctrl.alucontrol = ALU_OR;
            end
            OP_SLTI: begin
                ctrl.regwrite   = 1'b1;
                ctrl.alusrc     = 1'b1;
                ctrl.alucontrol = ALU_SLT;
            end
`endif
            default: illegal = 1'b1;
        endcase
        // Illegal encodings travel down the pipe as uncounted NOPs.
        if (illegal) begin
            ctrl = CTRL_BUBBLE;
        end else begin
            ctrl.valid = 1'b1;
        end
    end

    assign ctrl_o    = ctrl;
    assign illegal_o = illegal;

endmodule

// File: rtl/pipelined_controller.sv
// Decode-stage MIPS controller carrying its control word through E/M/W and counting retirements.
// PIPECTRL_IMM_LOGIC_EN (in ctrl_decode) enables andi/ori/slti; ports are identical either way.
module pipelined_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned ALUCTRL_W    = 3,
    parameter int unsigned RETIRE_CNT_W = 16
) (
    input logic        clk,
    input logic        reset,
    pipe_ctrl_if.slave bus
);

    ctrl_t                   dec_ctrl;
    ctrl_t                   e_d, e_q;
    mem_ctrl_t               m_d, m_q;
    wb_ctrl_t                w_d, w_q;
    logic [RETIRE_CNT_W-1:0] cnt_d, cnt_q;

    ctrl_decode u_decode (
        .opcode_i  (bus.opcodeD),
        .funct_i   (bus.functD),
        .ctrl_o    (dec_ctrl),
        .branch_o  (bus.branchD),
        .jump_o    (bus.jumpD),
        .illegal_o (bus.illegalD)
    );

    always_comb begin
        e_d = e_q;
        if (bus.flushE) begin
            e_d = CTRL_BUBBLE;
        end else if (!bus.stallE) begin
            e_d = dec_ctrl;
        end

        // A stalled E stage leaves nothing to hand on, so M takes a bubble.
        m_d = '{regwrite: e_q.regwrite, memtoreg: e_q.memtoreg,
                memwrite: e_q.memwrite, valid: e_q.valid};
        if (bus.stallE) begin
            m_d = '0;
        end

        w_d = '{regwrite: m_q.regwrite, memtoreg: m_q.memtoreg, valid: m_q.valid};

        cnt_d = cnt_q;
        if (w_q.valid) begin
            cnt_d = cnt_q + RETIRE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q   <= CTRL_BUBBLE;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.regwriteE   = e_q.regwrite;
    assign bus.memtoregE   = e_q.memtoreg;
    assign bus.memwriteE   = e_q.memwrite;
    assign bus.alusrcE     = e_q.alusrc;
    assign bus.regdstE     = e_q.regdst;
    assign bus.zeroextE    = e_q.zeroext;
    assign bus.alucontrolE = ALUCTRL_W'(e_q.alucontrol);
    assign bus.regwriteM   = m_q.regwrite;
    assign bus.memtoregM   = m_q.memtoreg;
    assign bus.memwriteM   = m_q.memwrite;
    assign bus.regwriteW   = w_q.regwrite;
    assign bus.memtoregW   = w_q.memtoreg;
    assign bus.validW      = w_q.valid;
    assign bus.retire_cnt  = cnt_q;

endmodule

// File: tb/tb_pipelined_controller.sv
// Directed table-driven bench for pipelined_controller with a small stage model and hand sequences.
module tb_pipelined_controller;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.ALUCTRL_W(3), .RETIRE_CNT_W(CW)) bus ();

    pipelined_controller #(.ALUCTRL_W(3), .RETIRE_CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic br, jp, il, rw, mtr, mw, as, rd, ze;
        logic [2:0] alu;
    } vec_t;

    typedef struct packed {
        logic rw, mtr, mw, as, rd, ze;
        logic [2:0] alu;
        logic v;
    } exp_t;

    exp_t          m_e, m_m, m_w;
    logic [CW-1:0] m_cnt;
    bit            known = 1'b0;
    int            passed = 0;
    int            total = 0;
    vec_t          tbl[$];
    vec_t v_lw, v_sw, v_add, v_sub, v_beq, v_addi, v_ori, v_slti, v_ill_op, v_ill_fn;

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn,
                                input logic br, input logic jp, input logic il,
                                input logic rw, input logic mtr, input logic mw,
                                input logic as, input logic rd, input logic ze,
                                input logic [2:0] alu);
        vec_t v;
        v = '{op: op, fn: fn, br: br, jp: jp, il: il, rw: rw, mtr: mtr, mw: mw,
              as: as, rd: rd, ze: ze, alu: alu};
        return v;
    endfunction

    function automatic exp_t dec_of(input vec_t v);
        exp_t e;
        e = '{rw: v.rw, mtr: v.mtr, mw: v.mw, as: v.as, rd: v.rd, ze: v.ze,
              alu: v.alu, v: !v.il};
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_edge(input bit rst, input bit stall, input bit flush, input exp_t d);
        if (rst) m_cnt = '0;
        else if (m_w.v) m_cnt = m_cnt + 1'b1;
        m_w = rst ? '0 : m_m;
        m_m = (rst || stall) ? '0 : m_e;
        if (rst || flush) m_e = '0;
        else if (!stall) m_e = d;
    endtask

    task automatic check_regs();
        chk("regwriteE", 32'(bus.regwriteE), 32'(m_e.rw));
        chk("memtoregE", 32'(bus.memtoregE), 32'(m_e.mtr));
        chk("memwriteE", 32'(bus.memwriteE), 32'(m_e.mw));
        chk("alusrcE", 32'(bus.alusrcE), 32'(m_e.as));
        chk("regdstE", 32'(bus.regdstE), 32'(m_e.rd));
        chk("zeroextE", 32'(bus.zeroextE), 32'(m_e.ze));
        chk("alucontrolE", 32'(bus.alucontrolE), 32'(m_e.alu));
        chk("regwriteM", 32'(bus.regwriteM), 32'(m_m.rw));
        chk("memtoregM", 32'(bus.memtoregM), 32'(m_m.mtr));
        chk("memwriteM", 32'(bus.memwriteM), 32'(m_m.mw));
        chk("regwriteW", 32'(bus.regwriteW), 32'(m_w.rw));
        chk("memtoregW", 32'(bus.memtoregW), 32'(m_w.mtr));
        chk("validW", 32'(bus.validW), 32'(m_w.v));
        chk("retire_cnt", 32'(bus.retire_cnt), 32'(m_cnt));
    endtask

    // Drive one decode slot, check at the negedge, then advance model and DUT together.
    task automatic cycle(input vec_t v, input bit stall, input bit flush, input bit rst);
        reset       = rst;
        bus.opcodeD = v.op;
        bus.functD  = v.fn;
        bus.stallE  = stall;
        bus.flushE  = flush;
        @(negedge clk);
        chk("branchD", 32'(bus.branchD), 32'(v.br));
        chk("jumpD", 32'(bus.jumpD), 32'(v.jp));
        chk("illegalD", 32'(bus.illegalD), 32'(v.il));
        if (known) check_regs();
        @(posedge clk);
        model_edge(rst, stall, flush, dec_of(v));
        if (rst) known = 1'b1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(v_ill_op, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        v_lw     = mk(6'b100011, 6'b000000, 0, 0, 0, 1, 1, 0, 1, 0, 0, 3'b010);
        v_sw     = mk(6'b101011, 6'b000000, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3'b010);
        v_add    = mk(6'b000000, 6'b100000, 0, 0, 0, 1, 0, 0, 0, 1, 0, 3'b010);
        v_sub    = mk(6'b000000, 6'b100010, 0, 0, 0, 1, 0, 0, 0, 1, 0, 3'b110);
        v_beq    = mk(6'b000100, 6'b000000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b110);
        v_addi   = mk(6'b001000, 6'b000000, 0, 0, 0, 1, 0, 0, 1, 0, 0, 3'b010);
        v_ill_op = mk(6'b111111, 6'b000000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000);
        v_ill_fn = mk(6'b000000, 6'b000000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000);
`ifdef PIPECTRL_IMM_LOGIC_EN
        v_ori  = mk(6'b001101, 6'b000000, 0, 0, 0, 1, 0, 0, 1, 0, 1, 3'b001);
        v_slti = mk(6'b001010, 6'b000000, 0, 0, 0, 1, 0, 0, 1, 0, 0, 3'b111);
        tbl.push_back(mk(6'b001100, 6'b000000, 0, 0, 0, 1, 0, 0, 1, 0, 1, 3'b000));
`else
        v_ori  = mk(6'b001101, 6'b000000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000);
        v_slti = mk(6'b001010, 6'b000000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000);
        tbl.push_back(mk(6'b001100, 6'b000000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000));
`endif
        tbl.push_back(v_lw);
        tbl.push_back(v_sw);
        tbl.push_back(v_add);
        tbl.push_back(v_sub);
        tbl.push_back(mk(6'b000000, 6'b100100, 0, 0, 0, 1, 0, 0, 0, 1, 0, 3'b000));
        tbl.push_back(mk(6'b000000, 6'b100101, 0, 0, 0, 1, 0, 0, 0, 1, 0, 3'b001));
        tbl.push_back(mk(6'b000000, 6'b101010, 0, 0, 0, 1, 0, 0, 0, 1, 0, 3'b111));
        tbl.push_back(v_beq);
        tbl.push_back(v_addi);
        tbl.push_back(mk(6'b000010, 6'b000000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        tbl.push_back(v_ill_op);
        tbl.push_back(v_ill_fn);
        tbl.push_back(mk(6'b000000, 6'b111111, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000));
        tbl.push_back(v_ori);
        tbl.push_back(v_slti);

        // Reset, then lw/sw/add/beq back to back.
        cycle(v_ill_op, 0, 0, 1);
        cycle(v_ill_op, 0, 0, 1);
        chk("reset regwriteE", 32'(bus.regwriteE), 0);
        chk("reset validW", 32'(bus.validW), 0);
        chk("reset retire_cnt", 32'(bus.retire_cnt), 0);
        cycle(v_lw, 0, 0, 0);
        chk("lw regwriteE", 32'(bus.regwriteE), 1);
        cycle(v_sw, 0, 0, 0);
        cycle(v_add, 0, 0, 0);
        chk("lw regwriteW", 32'(bus.regwriteW), 1);
        chk("lw memtoregW", 32'(bus.memtoregW), 1);
        chk("sw memwriteM", 32'(bus.memwriteM), 1);
        cycle(v_beq, 0, 0, 0);
        idle(3);
        chk("four retired", 32'(bus.retire_cnt), 4);

        // sub then two stall cycles.
        cycle(v_sub, 0, 0, 0);
        chk("sub aluE", 32'(bus.alucontrolE), 3'b110);
        for (int i = 0; i < 2; i++) begin
            cycle(v_ill_op, 1, 0, 0);
            chk("stall aluE held", 32'(bus.alucontrolE), 3'b110);
            chk("stall M bubble", 32'(bus.regwriteM), 0);
        end
        cycle(v_ill_op, 0, 0, 0);
        chk("sub reaches M", 32'(bus.regwriteM), 1);
        idle(3);
        chk("sub counted once", 32'(bus.retire_cnt), 5);

        // flush and stall together.
        cycle(v_add, 1, 1, 0);
        chk("flush E bubble", 32'(bus.regwriteE), 0);
        cycle(v_ill_op, 0, 0, 0);
        chk("flush M bubble", 32'(bus.regwriteM), 0);
        idle(3);
        chk("flushed not counted", 32'(bus.retire_cnt), 5);

        // Illegal encodings retire as bubbles.
        cycle(v_ill_op, 0, 0, 0);
        cycle(v_add, 0, 0, 0);
        cycle(v_add, 0, 0, 0);
        chk("illegal op validW", 32'(bus.validW), 0);
        cycle(v_ill_fn, 0, 0, 0);
        cycle(v_add, 0, 0, 0);
        cycle(v_add, 0, 0, 0);
        chk("illegal funct validW", 32'(bus.validW), 0);
        cycle(v_ill_op, 0, 0, 0);
        chk("add after illegal validW", 32'(bus.validW), 1);

        // Immediate logic ops.
        cycle(v_ori, 0, 0, 0);
`ifdef PIPECTRL_IMM_LOGIC_EN
        chk("ori aluE", 32'(bus.alucontrolE), 3'b001);
        chk("ori zeroextE", 32'(bus.zeroextE), 1);
        chk("ori alusrcE", 32'(bus.alusrcE), 1);
        cycle(v_slti, 0, 0, 0);
        chk("slti aluE", 32'(bus.alucontrolE), 3'b111);
        chk("slti zeroextE", 32'(bus.zeroextE), 0);
`else
        chk("ori illegal regwriteE", 32'(bus.regwriteE), 0);
        chk("ori illegal zeroextE", 32'(bus.zeroextE), 0);
`endif

        for (int i = 0; i < tbl.size(); i++) cycle(tbl[i], 0, 0, 0);
        idle(4);

        // Counter wrap at 4 bits.
        cycle(v_ill_op, 0, 0, 1);
        for (int i = 0; i < 17; i++) cycle(v_addi, 0, 0, 0);
        idle(4);
        chk("retire wrap", 32'(bus.retire_cnt), 1);

        // Reset mid-stream.
        cycle(v_lw, 0, 0, 0);
        cycle(v_add, 0, 0, 0);
        cycle(v_sw, 0, 0, 0);
        cycle(v_addi, 0, 0, 1);
        chk("mid reset regwriteE", 32'(bus.regwriteE), 0);
        chk("mid reset alusrcE", 32'(bus.alusrcE), 0);
        chk("mid reset regwriteM", 32'(bus.regwriteM), 0);
        chk("mid reset memtoregW", 32'(bus.memtoregW), 0);
        chk("mid reset validW", 32'(bus.validW), 0);
        chk("mid reset retire_cnt", 32'(bus.retire_cnt), 0);
        idle(2);
        chk("post reset retire_cnt", 32'(bus.retire_cnt), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
